// File: rtl/regfile_2w4r_pkg.sv
// Shared definitions for the dual-issue integer register file.
//
// Contents:
//   REG_ADDR_W - register index width (log2 of NREGS)
//   XLEN       - architectural register width
//   NREGS      - number of architectural registers (x0 hardwired to zero)
//   REG_WE     - bit position of the register-write enable on the ctrl bus
//   addr_hit   - true when a write port targets a given read index
//   same_dest  - true when both write slots target the same nonzero index
package regfile_2w4r_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_WE     = 3;

    function automatic logic addr_hit(input logic                  we,
                                      input logic [REG_ADDR_W-1:0] waddr,
                                      input logic [REG_ADDR_W-1:0] raddr);
        return we && (waddr == raddr);
    endfunction

    function automatic logic same_dest(input logic                  we0,
                                       input logic                  we1,
                                       input logic [REG_ADDR_W-1:0] waddr0,
                                       input logic [REG_ADDR_W-1:0] waddr1);
        return we0 && we1 && (waddr0 == waddr1) && (waddr0 != '0);
    endfunction

endpackage

// File: rtl/regfile_2w4r_rdport.sv
// One read port of the register file with same-cycle write-through bypass.
//
// Ports:
//   rst_i     - register file reset; forces the read result to zero
//   raddr_i   - read index
//   we0_i, waddr0_i, wdata0_i - slot 0 write port (older instruction)
//   we1_i, waddr1_i, wdata1_i - slot 1 write port (younger instruction)
//   entry_i   - stored word at raddr_i
//   rdata_o   - combinational read result
module regfile_2w4r_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            rst_i,
    input  logic [AW-1:0]   raddr_i,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    input  logic [XLEN-1:0] entry_i,
    output logic [XLEN-1:0] rdata_o
);
    import regfile_2w4r_pkg::*;

    // x0 beats any bypass; slot 1 is younger so its data beats slot 0.
    always_comb begin
        rdata_o = entry_i;
        if (rst_i || (raddr_i == '0)) begin
            rdata_o = '0;
        end else if (addr_hit(we1_i, waddr1_i, raddr_i)) begin
            rdata_o = wdata1_i;
        end else if (addr_hit(we0_i, waddr0_i, raddr_i)) begin
            rdata_o = wdata0_i;
        end
    end

endmodule

// File: rtl/regfile_2w4r.sv
// Architectural integer register file: NREGS x XLEN, two write ports,
// four combinational read ports with same-cycle write-through bypass.
//
// Ports:
//   clk_i, rst_i                    - clock, asynchronous active-high reset
//   we0_i, waddr0_i, wdata0_i       - slot 0 writeback
//   we1_i, waddr1_i, wdata1_i       - slot 1 writeback (wins on same index)
//   raddr0_i..raddr3_i              - slot 0 rs1/rs2, slot 1 rs1/rs2 indices
//   rdata0_o..rdata3_o              - corresponding read data
//   wconflict_o                     - one-cycle flag: previous cycle had both
//                                     slots writing the same nonzero index
module regfile_2w4r #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    input  logic [AW-1:0]   raddr0_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    input  logic [AW-1:0]   raddr3_i,
    output logic [XLEN-1:0] rdata0_o,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    output logic [XLEN-1:0] rdata3_o,
    output logic            wconflict_o
);
    import regfile_2w4r_pkg::*;

    logic [XLEN-1:0] entries_q [NREGS];
    logic [XLEN-1:0] entries_d [NREGS];
    logic            wconflict_q;
    logic            wconflict_d;

    // Slot 1 is applied after slot 0 so it overwrites on a shared index.
    // Entry 0 is never written and stays at its reset value of zero.
    always_comb begin
        entries_d = entries_q;
        if (we0_i && (waddr0_i != '0)) begin
            entries_d[waddr0_i] = wdata0_i;
        end
        if (we1_i && (waddr1_i != '0)) begin
            entries_d[waddr1_i] = wdata1_i;
        end
        wconflict_d = same_dest(we0_i, we1_i, waddr0_i, waddr1_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                entries_q[i] <= '0;
            end
            wconflict_q <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            wconflict_q <= wconflict_d;
        end
    end

    assign wconflict_o = wconflict_q;

    logic [AW-1:0]   raddr_w [4];
    logic [XLEN-1:0] rdata_w [4];

    assign raddr_w[0] = raddr0_i;
    assign raddr_w[1] = raddr1_i;
    assign raddr_w[2] = raddr2_i;
    assign raddr_w[3] = raddr3_i;

    for (genvar g = 0; g < 4; g++) begin : g_rd
        regfile_2w4r_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdport (
            .rst_i    (rst_i),
            .raddr_i  (raddr_w[g]),
            .we0_i    (we0_i),
            .waddr0_i (waddr0_i),
            .wdata0_i (wdata0_i),
            .we1_i    (we1_i),
            .waddr1_i (waddr1_i),
            .wdata1_i (wdata1_i),
            .entry_i  (entries_q[raddr_w[g]]),
            .rdata_o  (rdata_w[g])
        );
    end

    assign rdata0_o = rdata_w[0];
    assign rdata1_o = rdata_w[1];
    assign rdata2_o = rdata_w[2];
    assign rdata3_o = rdata_w[3];

endmodule

// File: tb/tb_regfile_2w4r.sv
module tb_regfile_2w4r;

    logic        clk;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra [4];
    logic [31:0] rd [4];
    logic        wconf;

    int tests;
    int fails;

    // Reference state, updated independently of the DUT.
    logic [31:0] model [32];
    logic        conf_exp;
    logic [31:0] exp_q [$];

    regfile_2w4r dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .we0_i       (we0),
        .waddr0_i    (wa0),
        .wdata0_i    (wd0),
        .we1_i       (we1),
        .waddr1_i    (wa1),
        .wdata1_i    (wd1),
        .raddr0_i    (ra[0]),
        .raddr1_i    (ra[1]),
        .raddr2_i    (ra[2]),
        .raddr3_i    (ra[3]),
        .rdata0_o    (rd[0]),
        .rdata1_o    (rd[1]),
        .rdata2_o    (rd[2]),
        .rdata3_o    (rd[3]),
        .wconflict_o (wconf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (rst || a == 5'd0)        return 32'h0;
        if (we1 && wa1 == a)         return wd1;
        if (we0 && wa0 == a)         return wd0;
        return model[a];
    endfunction

    // Expected values for the four ports are queued as soon as stimulus settles.
    task automatic push_reads();
        for (int k = 0; k < 4; k++) exp_q.push_back(model_read(ra[k]));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        conf_exp = 1'b0;
    endtask

    // Advance one edge, update the reference, and land 1 time unit after it.
    task automatic commit();
        logic c;
        @(posedge clk);
        c = 1'b0;
        if (!rst) begin
            if (we0 && wa0 != 0) model[wa0] = wd0;
            if (we1 && wa1 != 0) model[wa1] = wd1;
            c = we0 && we1 && (wa0 == wa1) && (wa0 != 0);
        end
        conf_exp = c;
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    endtask

    task automatic set_ra(input logic [4:0] a0, a1, a2, a3);
        ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1; idle(); set_ra(5'd5, 5'd0, 5'd1, 5'd31);
        model_clear();
        #2;
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL reset_rd%0d got %h want %h", k, rd[k], e); end
        end
        tests++;
        if (wconf !== 1'b0) begin fails++; $display("FAIL reset_wconf got %b want 0", wconf); end
        commit();
        rst = 0;
        commit();
        // Write x5 and confirm it landed.
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        commit();
        idle();
        #1;
        push_reads();
        e = exp_q.pop_front(); tests++;
        if (rd[0] !== e || e !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_prewrite got %h want %h", rd[0], 32'hDEADBEEF); end
        void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
        // Asynchronous assertion mid-cycle: x5 must read zero before the next edge.
        #1 rst = 1;
        model_clear();
        #1;
        tests++;
        if (rd[0] !== 32'h0) begin fails++; $display("FAIL reset_async got %h want 0", rd[0]); end
        // A write presented during reset must be dropped.
        we0 = 1; wa0 = 5'd5; wd0 = 32'h12345678;
        commit();
        #2 rst = 0;
        idle();
        #1;
        tests++;
        if (rd[0] !== 32'h0) begin fails++; $display("FAIL reset_after_deassert got %h want 0", rd[0]); end
        commit();
        tests++;
        if (rd[0] !== 32'h0) begin fails++; $display("FAIL reset_held_zero got %h want 0", rd[0]); end
    endtask

    task automatic test_x0();
        logic [31:0] e;
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        #2;
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL x0_bypass_rd%0d got %h want %h", k, rd[k], e); end
        end
        commit();
        idle();
        #1;
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL x0_stored_rd%0d got %h want %h", k, rd[k], e); end
        end
        tests++;
        if (wconf !== 1'b0) begin fails++; $display("FAIL x0_wconf got %b want 0", wconf); end
    endtask

    task automatic test_conflict();
        logic [31:0] e;
        we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222;
        set_ra(5'd7, 5'd7, 5'd0, 5'd6);
        #2;
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL conflict_bypass_rd%0d got %h want %h", k, rd[k], e); end
        end
        tests++;
        if (rd[0] !== 32'h22222222) begin fails++; $display("FAIL conflict_younger got %h want 22222222", rd[0]); end
        commit();
        idle();
        #1;
        tests++;
        if (wconf !== 1'b1) begin fails++; $display("FAIL conflict_flag got %b want 1", wconf); end
        tests++;
        if (rd[0] !== 32'h22222222) begin fails++; $display("FAIL conflict_stored got %h want 22222222", rd[0]); end
        commit();
        tests++;
        if (wconf !== 1'b0) begin fails++; $display("FAIL conflict_flag_clear got %b want 0", wconf); end
    endtask

    task automatic test_dual_distinct();
        logic [31:0] e;
        we0 = 1; wa0 = 5'd3; wd0 = 32'hA;
        we1 = 1; wa1 = 5'd4; wd1 = 32'hB;
        commit();
        idle();
        set_ra(5'd3, 5'd4, 5'd4, 5'd3);
        #1;
        tests++;
        if (wconf !== 1'b0) begin fails++; $display("FAIL dual_wconf got %b want 0", wconf); end
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL dual_rd%0d got %h want %h", k, rd[k], e); end
        end
        tests++;
        if ({rd[0], rd[1], rd[2], rd[3]} !== {32'hA, 32'hB, 32'hB, 32'hA}) begin
            fails++; $display("FAIL dual_literal got %h %h %h %h want a b b a", rd[0], rd[1], rd[2], rd[3]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        we0 = 1; wa0 = 5'd9; wd0 = 32'h5;
        commit();
        wd0 = 32'h6;
        set_ra(5'd1, 5'd3, 5'd9, 5'd9);
        we1 = 1; wa1 = 5'd1; wd1 = 32'h77;
        #2;
        push_reads();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); tests++;
            if (rd[k] !== e) begin fails++; $display("FAIL bypass_rd%0d got %h want %h", k, rd[k], e); end
        end
        tests++;
        if (rd[2] !== 32'h6) begin fails++; $display("FAIL bypass_literal got %h want 6", rd[2]); end
        commit();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] e;
        bit          narrow;
        int          tf;
        tf = fails;
        for (int n = 0; n < 10000; n++) begin
            narrow = ($urandom_range(0, 1) == 1);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            for (int k = 0; k < 4; k++) ra[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
            #2;
            push_reads();
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); tests++;
                if (rd[k] !== e) begin
                    fails++;
                    if (fails - tf < 10) $display("FAIL random_rd%0d cycle %0d got %h want %h", k, n, rd[k], e);
                end
            end
            commit();
            tests++;
            if (wconf !== conf_exp) begin
                fails++;
                if (fails - tf < 10) $display("FAIL random_wconf cycle %0d got %b want %b", n, wconf, conf_exp);
            end
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_x0();
        test_conflict();
        test_dual_distinct();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_2w4r.md
Name: regfile_2w4r

Overview:
- Architectural integer register file for the dual-issue core: 32 x 32-bit, two write ports, four read ports.
- Sits directly downstream of writeback. It consumes rd_data0_o/rd_data1_o plus each slot's destination index and write-enable.
- Decode reads the four source operands (rs1/rs2 of each slot) from it.
- Handles the same-cycle write conflict between the two slots and write-to-read bypass within a cycle.

Parameters:
- XLEN, 32, register width
- NREGS, 32, number of architectural registers; x0 hardwired zero
- AW, 5, register index width, equal to log2(NREGS)

Ports:
- clk_i  input  1  core clock; writes commit on rising edge
- rst_i  input  1  asynchronous, active-high reset
- we0_i  input  1  slot 0 write enable; from ctrl_0 register-write bit
- waddr0_i  input  AW  slot 0 destination index
- wdata0_i  input  XLEN  slot 0 write data (writeback rd_data0_o)
- we1_i  input  1  slot 1 write enable
- waddr1_i  input  AW  slot 1 destination index
- wdata1_i  input  XLEN  slot 1 write data (writeback rd_data1_o)
- raddr0_i  input  AW  slot 0 rs1 index
- raddr1_i  input  AW  slot 0 rs2 index
- raddr2_i  input  AW  slot 1 rs1 index
- raddr3_i  input  AW  slot 1 rs2 index
- rdata0_o  output  XLEN  slot 0 rs1 data
- rdata1_o  output  XLEN  slot 0 rs2 data
- rdata2_o  output  XLEN  slot 1 rs1 data
- rdata3_o  output  XLEN  slot 1 rs2 data
- wconflict_o  output  1  registered pulse: previous cycle had both slots writing the same nonzero index

Behaviour:
- Reset (rst_i high, asynchronous): all NREGS entries clear to 0 and wconflict_o clears to 0, immediately and independent of clk_i.
  - Read outputs are combinational, so they read 0 while in reset.
  - Writes presented while rst_i is high are dropped.
  - Deassertion takes effect from the next rising edge.
- Write: on the rising edge, if weN_i is high and waddrN_i != 0, entry[waddrN_i] <= wdataN_i.
  - Write latency is 1 edge.
  - Writes to x0 are ignored; entry 0 always reads 0.
- Dual-write conflict: if we0_i && we1_i && waddr0_i == waddr1_i != 0, slot 1 (program-order younger) wins. Slot 0's data is discarded.
  - wconflict_o goes to 1 for exactly the next cycle; it is informational only.
- Different-index dual write: both commit on the same edge.
- Read: combinational, zero-cycle, with same-cycle write-through bypass. Priority for each port k:
  1. raddrk_i == 0 gives 0 (even if a write targets 0).
  2. we1_i && waddr1_i == raddrk_i gives wdata1_i.
  3. we0_i && waddr0_i == raddrk_i gives wdata0_i.
  4. Otherwise the stored entry[raddrk_i].
- Bypass is gated by rst_i: in reset, reads return 0.
- The four read ports are fully independent. Any or all may hit the same index or the same bypass source.
- No stall or handshake. Writeback presents valid data every cycle its enable is high; enables for bubbles and flushed slots arrive low.
- Out-of-range indices are impossible, since AW equals log2(NREGS).

Decomposition:
- Shared defs.v gains REG_ADDR_W (5), XLEN (32), NREGS (32) and the ctrl-bus register-write bit position (REG_WE), consumed by the instantiating core.
- One natural sub-module: regfile_rdport. It is the per-port bypass mux (raddr, both write-port triples, storage word, rst) and is instantiated four times.
- Storage and the write logic stay in the top module.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse rst_i mid-cycle (asynchronously) -> rdata for x5 reads 0 immediately, before the next edge; it stays 0 after deassert until rewritten.
- x0: we0_i=1, waddr0_i=0, wdata0_i=0xFFFFFFFF -> all ports with raddr=0 read 0 in the same cycle and after the edge.
- Conflict: we0_i=we1_i=1, both waddr=7, wdata0=0x11111111, wdata1=0x22222222 -> same-cycle read of x7 gives 0x22222222, stored x7 = 0x22222222 after the edge, wconflict_o=1 for exactly one cycle.
- Dual distinct: slot 0 writes x3=0xA, slot 1 writes x4=0xB on one edge; next cycle read ports 0-3 at x3,x4,x4,x3 -> 0xA,0xB,0xB,0xA.
- Bypass: x9 holds 0x5; this cycle slot 0 writes x9=0x6 and raddr2_i=9 -> rdata2_o=0x6 combinationally, before the edge.
- Random regression: 10k cycles of random we/addr/data against a reference-model array with the same priority rules. All four read outputs must match every cycle.
